// File: rtl/core_pkg.sv
// Shared sequencer state encoding for the sequencer, decoder and datapath.
package core_pkg;

   localparam logic [2:0] FETCH  = 3'd0;
   localparam logic [2:0] DECODE = 3'd1;
   localparam logic [2:0] EXEC   = 3'd2;
   localparam logic [2:0] MEM    = 3'd3;
   localparam logic [2:0] WRITE  = 3'd4;

   typedef enum logic [2:0] {
      ST_FETCH  = FETCH,
      ST_DECODE = DECODE,
      ST_EXEC   = EXEC,
      ST_MEM    = MEM,
      ST_WRITE  = WRITE
   } state_t;

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer with handshake stalls and retire counter.
//
// state  | meaning
// FETCH  | request instruction word; wait for run && imem_ready
// DECODE | one cycle for the decoder to settle
// EXEC   | FPU / UART-in / UART-out / ALU sub-operation, stalls on handshake
// MEM    | hold dmem_req until dmem_ready
// WRITE  | commit results, bump retired count
module core_sequencer
   import core_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   input  logic             fpu_done,
   input  logic             rx_valid,
   input  logic             tx_ready,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             use_fpu,
   input  logic             data_in,
   input  logic             data_out,
   output logic [2:0]       state,
   output logic             imem_req,
   output logic             instr_we,
   output logic             fpu_start,
   output logic             dmem_req,
   output logic             rx_pop,
   output logic             tx_push,
   output logic             commit,
   output logic [CNT_W-1:0] retired
);

   state_t state_q;
   logic   fpu_busy;
   logic   exec_done;
   logic   live;

   // EXEC completion condition, FPU first, then UART in, then UART out.
   // fpu_done only counts once fpu_busy is set, so it is ignored in the start cycle.
   always_comb begin
      exec_done = 1'b1;
      if (use_fpu)       exec_done = fpu_busy && fpu_done;
      else if (data_in)  exec_done = rx_valid;
      else if (data_out) exec_done = tx_ready;
   end

   // Main sequencer FSM plus FPU-busy tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_FETCH;
         fpu_busy <= 1'b0;
      end else begin
         case (state_q)
            ST_FETCH:  if (run && imem_ready) state_q <= ST_DECODE;
            ST_DECODE: state_q <= ST_EXEC;
            ST_EXEC: begin
               if (use_fpu && !fpu_busy)      fpu_busy <= 1'b1;
               else if (fpu_busy && fpu_done) fpu_busy <= 1'b0;
               if (exec_done) state_q <= (mem_read || mem_write) ? ST_MEM : ST_WRITE;
            end
            ST_MEM:    if (dmem_ready) state_q <= ST_WRITE;
            ST_WRITE:  state_q <= ST_FETCH;
            default:   state_q <= ST_FETCH;
         endcase
      end
   end

   // Retired-instruction counter, wraps naturally at 2^CNT_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      retired <= '0;
      else if (state_q == ST_WRITE) retired <= retired + CNT_W'(1);
   end

   // Strobes are forced low while reset is asserted so requests drop at once.
   assign live      = ~rst;
   assign state     = state_q;
   assign imem_req  = live && (state_q == ST_FETCH) && run;
   assign instr_we  = live && (state_q == ST_FETCH) && run && imem_ready;
   assign fpu_start = live && (state_q == ST_EXEC) && use_fpu && !fpu_busy;
   assign rx_pop    = live && (state_q == ST_EXEC) && !use_fpu && data_in && rx_valid;
   assign tx_push   = live && (state_q == ST_EXEC) && !use_fpu && !data_in && data_out && tx_ready;
   assign dmem_req  = live && (state_q == ST_MEM);
   assign commit    = live && (state_q == ST_WRITE);

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer: each instruction is expanded into an
// expected per-cycle trace from its timing rules, then driven and compared.
module tb_core_sequencer;

   localparam int CW = 4;

   localparam logic [6:0] S_IMEM = 7'b1000000;
   localparam logic [6:0] S_IWE  = 7'b0100000;
   localparam logic [6:0] S_FPU  = 7'b0010000;
   localparam logic [6:0] S_DMEM = 7'b0001000;
   localparam logic [6:0] S_RXP  = 7'b0000100;
   localparam logic [6:0] S_TXP  = 7'b0000010;
   localparam logic [6:0] S_COM  = 7'b0000001;

   typedef struct packed {
      logic          run, imem_ready, dmem_ready, fpu_done, rx_valid, tx_ready;
      logic          mem_read, mem_write, use_fpu, data_in, data_out;
      logic [2:0]    st;
      logic [6:0]    strb;
      logic [CW-1:0] ret;
   } cyc_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          run, imem_ready, dmem_ready, fpu_done, rx_valid, tx_ready;
   logic          mem_read, mem_write, use_fpu, data_in, data_out;
   logic [2:0]    state;
   logic          imem_req, instr_we, fpu_start, dmem_req, rx_pop, tx_push, commit;
   logic [CW-1:0] retired;

   core_sequencer #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .run(run), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .fpu_done(fpu_done), .rx_valid(rx_valid),
      .tx_ready(tx_ready), .mem_read(mem_read), .mem_write(mem_write),
      .use_fpu(use_fpu), .data_in(data_in), .data_out(data_out),
      .state(state), .imem_req(imem_req), .instr_we(instr_we),
      .fpu_start(fpu_start), .dmem_req(dmem_req), .rx_pop(rx_pop),
      .tx_push(tx_push), .commit(commit), .retired(retired)
   );

   always #5 clk = ~clk;

   cyc_t          q[$];
   cyc_t          cur;
   logic          cur_valid = 1'b0;
   logic          hold = 1'b1;
   logic [CW-1:0] m_ret = '0;
   int            plan_len = 0;
   int            n_chk = 0;
   int            n_fail = 0;
   int            cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic apply(input cyc_t c);
      run = c.run; imem_ready = c.imem_ready; dmem_ready = c.dmem_ready;
      fpu_done = c.fpu_done; rx_valid = c.rx_valid; tx_ready = c.tx_ready;
      mem_read = c.mem_read; mem_write = c.mem_write; use_fpu = c.use_fpu;
      data_in = c.data_in; data_out = c.data_out;
   endtask

   task automatic apply_idle();
      cyc_t c;
      c = '0;
      apply(c);
   endtask

   function automatic cyc_t rnd();
      cyc_t c;
      c.run = 1'($urandom); c.imem_ready = 1'($urandom); c.dmem_ready = 1'($urandom);
      c.fpu_done = 1'($urandom); c.rx_valid = 1'($urandom); c.tx_ready = 1'($urandom);
      c.mem_read = 1'($urandom); c.mem_write = 1'($urandom); c.use_fpu = 1'($urandom);
      c.data_in = 1'($urandom); c.data_out = 1'($urandom);
      c.st = 3'd0; c.strb = '0; c.ret = m_ret;
      return c;
   endfunction

   task automatic push(input cyc_t c);
      q.push_back(c);
      plan_len++;
   endtask

   // kind: 0 ALU, 1 FPU, 2 UART in, 3 UART out.  w = FPU N or UART wait cycles.
   task automatic plan_instr(input int kind, input bit rd, input bit wr, input int r,
                             input int k, input int w, input int mm, input bit done0,
                             output int n);
      cyc_t c;
      int   start = plan_len;
      for (int i = 0; i < r; i++) begin
         c = rnd(); c.run = 1'b0; push(c);
      end
      for (int i = 0; i < k; i++) begin
         c = rnd(); c.run = 1'b1; c.imem_ready = 1'b0; c.strb = S_IMEM; push(c);
      end
      c = rnd(); c.run = 1'b1; c.imem_ready = 1'b1; c.strb = S_IMEM | S_IWE; push(c);
      c = rnd(); c.st = 3'd1; push(c);
      for (int i = 0; i <= ((kind == 0) ? 0 : w); i++) begin
         c = rnd(); c.st = 3'd2;
         c.use_fpu = (kind == 1); c.data_in = (kind == 2); c.data_out = (kind == 3);
         c.mem_read = rd; c.mem_write = wr;
         if (kind == 1) begin
            c.fpu_done = (i == 0) ? done0 : (i == w);
            if (i == 0) c.strb = S_FPU;
         end else if (kind == 2) begin
            c.rx_valid = (i == w);
            if (i == w) c.strb = S_RXP;
         end else if (kind == 3) begin
            c.tx_ready = (i == w);
            if (i == w) c.strb = S_TXP;
         end
         push(c);
      end
      if (rd || wr) begin
         for (int i = 0; i <= mm; i++) begin
            c = rnd(); c.st = 3'd3; c.dmem_ready = (i == mm); c.strb = S_DMEM; push(c);
         end
      end
      c = rnd(); c.st = 3'd4; c.strb = S_COM; push(c);
      m_ret = m_ret + CW'(1);
      n = plan_len - start;
   endtask

   task automatic drain();
      int t = 0;
      while ((q.size() > 0 || cur_valid) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      n_chk++;
      if (t >= 5000) begin
         n_fail++;
         $display("FAIL drain timeout at cycle %0d: queue %0d left, expected 0", cyc, q.size());
      end
   endtask

   // Driver: one planned cycle per clock, applied just after the rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!hold) begin
            if (q.size() > 0) begin
               cur = q.pop_front();
               apply(cur);
               cur_valid = 1'b1;
            end else begin
               apply_idle();
               cur_valid = 1'b0;
            end
         end
      end
   end

   // Compare process: checks every planned cycle on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (cur_valid && !rst) begin
            chk("state", 32'(state), 32'(cur.st));
            chk("strobes", 32'({imem_req, instr_we, fpu_start, dmem_req, rx_pop, tx_push, commit}),
                32'(cur.strb));
            chk("retired", 32'(retired), 32'(cur.ret));
         end
      end
   end

   initial begin
      int n;
      int t;
      rst = 1'b1;
      apply_idle();
      run = 1'b1; imem_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_retired", 32'(retired), 32'd0);
      chk("reset_imem_req", 32'(imem_req), 32'd0);
      chk("reset_instr_we", 32'(instr_we), 32'd0);
      apply_idle();
      rst = 1'b0;
      hold = 1'b0;

      plan_instr(0, 0, 0, 0, 0, 0, 0, 0, n);
      chk("len_alu", 32'(n), 32'd4);
      plan_instr(0, 1, 0, 0, 0, 0, 3, 0, n);
      chk("len_load_stall", 32'(n), 32'd8);
      plan_instr(1, 0, 0, 0, 0, 6, 0, 1, n);
      chk("len_fpu6", 32'(n), 32'd10);
      plan_instr(2, 0, 0, 0, 0, 3, 0, 0, n);
      chk("len_rx_wait3", 32'(n), 32'd7);
      plan_instr(3, 0, 0, 0, 0, 3, 0, 0, n);
      chk("len_tx_wait3", 32'(n), 32'd7);
      plan_instr(0, 0, 0, 3, 0, 0, 0, 0, n);
      chk("len_alu_run_low3", 32'(n), 32'd7);
      drain();
      chk("retired_after_directed", 32'(retired), 32'd6);

      for (int i = 0; i < 150; i++) begin
         plan_instr($urandom_range(3, 0), 1'($urandom), 1'($urandom),
                    $urandom_range(2, 0), $urandom_range(2, 0),
                    $urandom_range(4, 1), $urandom_range(3, 0), 1'($urandom), n);
      end
      drain();

      // Reset in the middle of a stalled load.
      plan_instr(0, 0, 0, 0, 0, 0, 0, 0, n);
      plan_instr(0, 1, 0, 0, 0, 0, 10, 0, n);
      t = 0;
      while (!(cur_valid && cur.st == 3'd3) && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("reach_mem_before_reset", 32'(t < 200), 32'd1);
      @(negedge clk);
      #2;
      hold = 1'b1;
      q.delete();
      cur_valid = 1'b0;
      apply_idle();
      rst = 1'b1;
      #1;
      chk("rst_dmem_req", 32'(dmem_req), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_retired", 32'(retired), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      m_ret = '0;
      hold = 1'b0;

      // Counter wrap.
      for (int i = 0; i < 15; i++) plan_instr(0, 0, 0, 0, 0, 0, 0, 0, n);
      drain();
      chk("retired_15", 32'(retired), 32'd15);
      plan_instr(0, 0, 0, 0, 0, 0, 0, 0, n);
      drain();
      chk("retired_wrap_0", 32'(retired), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
